i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
- Command sequencer upstream of the i2c_cpu word-level I2C master. Feeds its WE/DATA_IN port and polls its DATA_OUT status word.
- Turns a single host request into a full register transaction, so flight logic does not hand-sequence bus primitives:
  - single-register write, or
  - burst read of up to 15 consecutive registers (IMU/magnetometer polling).
- Received bytes are streamed out with a valid strobe and an index.

Parameters:
TIMEOUT_CYCLES, 65535, max CLK cycles to wait for one i2c_cpu primitive to finish before aborting with ERROR (16-bit counter).

Ports:
CLK  in  1  system clock (same clock as i2c_cpu CLK)
RESET_N  in  1  asynchronous active-low reset
GO  in  1  one-cycle request strobe; sampled only when BUSY=0
WR  in  1  1 = write WDATA to REG_ADDR; 0 = burst read COUNT bytes from REG_ADDR
DEV_ADDR  in  7  7-bit slave address
REG_ADDR  in  8  first register address
WDATA  in  8  write data (WR=1)
COUNT  in  4  read length, 0..15 (WR=0)
BUSY  out  1  transaction in progress
DONE  out  1  one-cycle pulse at transaction end (success or error)
ERROR  out  1  NACK or timeout in last transaction; held until next accepted GO
RD_DATA  out  8  received byte
RD_VALID  out  1  one-cycle pulse, RD_DATA/RD_INDEX valid
RD_INDEX  out  4  byte index within burst, 0-based
CPU_WE  out  1  to i2c_cpu WE
CPU_DATA_IN  out  32  to i2c_cpu DATA_IN
CPU_DATA_OUT  in  32  from i2c_cpu DATA_OUT (bit31 busy, bit8 ack, [7:0] byte)

Behaviour:
- Reset values: BUSY, DONE, ERROR, RD_VALID, CPU_WE = 0; RD_DATA, RD_INDEX, CPU_DATA_IN = 0; FSM in IDLE.
- Primitive encodings on CPU_DATA_IN; all other bits are 0:
  - START: 0x0004_0000
  - STOP: 0x0001_0000
  - write byte b: 0x0002_0100 | b
  - read with ACK: 0x0002_00FF
  - read with NACK: 0x0002_01FF
- Primitive issue protocol:
  - ISSUE: CPU_WE=1 for exactly one cycle with CPU_DATA_IN valid.
  - HOLD: one mandatory cycle, because i2c_cpu busy is not visible until the cycle after WE.
  - WAIT: poll CPU_DATA_OUT[31] until 0, then evaluate and advance.
  - CPU_DATA_IN holds its value from ISSUE until the next ISSUE.
- Timeout:
  - The timeout counter clears at each ISSUE and increments in WAIT.
  - Reaching TIMEOUT_CYCLES → ERROR=1, DONE pulse, go to IDLE with no STOP issued (the bus is assumed hung).
- GO accepted in IDLE only:
  - Latch WR, DEV_ADDR, REG_ADDR, WDATA, COUNT.
  - Clear ERROR; BUSY=1 from the next cycle.
  - GO while BUSY is ignored.
- Sequence for WR=1: START → write {DEV_ADDR,0} → write REG_ADDR → write WDATA → STOP → FINISH.
- Sequence for WR=0: START → write {DEV_ADDR,0} → write REG_ADDR → STOP → START → write {DEV_ADDR,1} → COUNT reads → STOP → FINISH.
  - i2c_cpu cannot issue a repeated start, so the sequence uses STOP+START instead.
  - COUNT=0: stop after the first STOP (pointer set only), then FINISH with no RD_VALID.
- Read bytes:
  - Reads 0..COUNT-2 use read-ACK; the last read uses read-NACK.
  - After each read completes: RD_DATA = CPU_DATA_OUT[7:0], RD_INDEX = index, RD_VALID pulse for one cycle.
- Ack check after every write-byte primitive: CPU_DATA_OUT[8]=1 means NACK → ERROR=1, issue STOP, then FINISH (DONE pulse). Remaining steps are skipped.
- FINISH: DONE=1 for one cycle, BUSY=0 in the same cycle, then IDLE. A GO in the cycle after DONE is accepted.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. No STOP is generated; i2c_cpu shares RESET and is cleared by it.
- Width rules:
  - Read index counter is 4 bits and never wraps, since COUNT ≤ 15.
  - Timeout counter is 16 bits and saturates at TIMEOUT_CYCLES.

Test Plan:
- Write, all ACK: GO, WR=1, DEV_ADDR=0x68, REG_ADDR=0x6B, WDATA=0x00 → CPU_WE words in order 0x40000, 0x201D0, 0x2016B, 0x20100, 0x10000; DONE pulse; ERROR=0.
- Burst read: GO, WR=0, DEV_ADDR=0x68, REG_ADDR=0x3B, COUNT=3; model returns 0x12, 0x34, 0x56 → words 0x40000, 0x201D0, 0x2013B, 0x10000, 0x40000, 0x201D1, 0x200FF, 0x200FF, 0x201FF, 0x10000; RD_VALID ×3 with (0,0x12), (1,0x34), (2,0x56); DONE.
- Address NACK: model returns CPU_DATA_OUT[8]=1 after the first write → next word 0x10000, then DONE with ERROR=1; no RD_VALID; ERROR clears on the next GO.
- Timeout: TIMEOUT_CYCLES=20; model holds bit31=1 after START → DONE and ERROR exactly 20 WAIT cycles later; no further CPU_WE.
- COUNT=0 and GO-while-busy: only 4 words issued, DONE, no RD_VALID; a second GO pulsed mid-transaction produces no extra words.
- Async reset: assert RESET_N=0 during the third read → BUSY, CPU_WE, RD_VALID drop immediately; after release, a fresh GO runs a full sequence correctly.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Drives the word-level i2c_cpu master through a complete register transaction
//   from a single host request: a single-register write, or a burst read of up to
//   15 consecutive registers. Received bytes stream out with a valid strobe and index.
//
// Ports
//   CLK, RESET_N           clock, asynchronous active-low reset
//   GO, WR                 request strobe (sampled only when idle), 1 = write / 0 = read
//   DEV_ADDR, REG_ADDR     7-bit slave address, first register address
//   WDATA, COUNT           write byte, burst read length (0..15)
//   BUSY, DONE, ERROR      status; DONE pulses once per transaction, ERROR held to next GO
//   RD_DATA/VALID/INDEX    received byte stream
//   CPU_WE, CPU_DATA_IN    primitive command to i2c_cpu
//   CPU_DATA_OUT           i2c_cpu status (bit31 busy, bit8 nack, [7:0] byte)
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        GO,
  input  logic        WR,
  input  logic [6:0]  DEV_ADDR,
  input  logic [7:0]  REG_ADDR,
  input  logic [7:0]  WDATA,
  input  logic [3:0]  COUNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  RD_DATA,
  output logic        RD_VALID,
  output logic [3:0]  RD_INDEX,
  output logic        CPU_WE,
  output logic [31:0] CPU_DATA_IN,
  input  logic [31:0] CPU_DATA_OUT
);

  localparam logic [31:0] CmdStart    = 32'h0004_0000;
  localparam logic [31:0] CmdStop     = 32'h0001_0000;
  localparam logic [31:0] CmdWrite    = 32'h0002_0100;
  localparam logic [31:0] CmdReadAck  = 32'h0002_00FF;
  localparam logic [31:0] CmdReadNack = 32'h0002_01FF;
  localparam logic [15:0] TmoLimit    = (TIMEOUT_CYCLES > 32'd65535) ? 16'hFFFF :
                                        16'(TIMEOUT_CYCLES);

  // Issue -> Hold -> Wait runs once per i2c_cpu primitive.
  typedef enum logic [1:0] {StIdle, StIssue, StHold, StWait} state_e;

  typedef enum logic [3:0] {
    SqStart, SqDevW, SqRegAddr, SqWdata, SqStopPtr,
    SqStart2, SqDevR, SqRead, SqStopEnd
  } step_e;

  state_e      state_q;
  step_e       step_q;
  logic        wr_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [3:0]  count_q;
  logic [3:0]  idx_q;
  logic [15:0] tmo_q;

  logic        cpu_busy;
  logic        cpu_nack;
  logic        unused_status;

  assign cpu_busy      = CPU_DATA_OUT[31];
  assign cpu_nack      = CPU_DATA_OUT[8];
  assign unused_status = ^CPU_DATA_OUT[30:9];

  // Decision taken when the current primitive completes (busy low in Wait).
  step_e      nxt_step;
  logic [3:0] nxt_idx;
  logic       nxt_finish;
  logic       nxt_err;
  logic       rd_fire;

  always_comb begin
    nxt_step   = step_q;
    nxt_idx    = idx_q;
    nxt_finish = 1'b0;
    nxt_err    = 1'b0;
    rd_fire    = 1'b0;
    unique case (step_q)
      SqStart:  nxt_step = SqDevW;
      SqDevW: begin
        if (cpu_nack) begin
          nxt_err  = 1'b1;
          nxt_step = SqStopEnd;
        end else begin
          nxt_step = SqRegAddr;
        end
      end
      SqRegAddr: begin
        if (cpu_nack) begin
          nxt_err  = 1'b1;
          nxt_step = SqStopEnd;
        end else begin
          nxt_step = wr_q ? SqWdata : SqStopPtr;
        end
      end
      SqWdata: begin
        nxt_err  = cpu_nack;
        nxt_step = SqStopEnd;
      end
      // i2c_cpu has no repeated start, so the read phase reopens with STOP+START.
      SqStopPtr: begin
        if (count_q == 4'd0) nxt_finish = 1'b1;
        else                 nxt_step   = SqStart2;
      end
      SqStart2: nxt_step = SqDevR;
      SqDevR: begin
        if (cpu_nack) begin
          nxt_err  = 1'b1;
          nxt_step = SqStopEnd;
        end else begin
          nxt_step = SqRead;
          nxt_idx  = 4'd0;
        end
      end
      SqRead: begin
        rd_fire = 1'b1;
        if (idx_q == count_q - 4'd1) begin
          nxt_step = SqStopEnd;
        end else begin
          nxt_step = SqRead;
          nxt_idx  = idx_q + 4'd1;
        end
      end
      SqStopEnd: nxt_finish = 1'b1;
      default:   nxt_finish = 1'b1;
    endcase
  end

  logic [31:0] nxt_word;

  always_comb begin
    nxt_word = CmdStop;
    unique case (nxt_step)
      SqStart, SqStart2: nxt_word = CmdStart;
      SqDevW:            nxt_word = CmdWrite | {24'h0, dev_q, 1'b0};
      SqDevR:            nxt_word = CmdWrite | {24'h0, dev_q, 1'b1};
      SqRegAddr:         nxt_word = CmdWrite | {24'h0, reg_q};
      SqWdata:           nxt_word = CmdWrite | {24'h0, wdata_q};
      // Last byte of the burst is NACKed so the slave releases SDA.
      SqRead:            nxt_word = (nxt_idx == count_q - 4'd1) ? CmdReadNack : CmdReadAck;
      default:           nxt_word = CmdStop;
    endcase
  end

  logic [15:0] tmo_inc;
  logic        tmo_expired;

  assign tmo_inc     = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
  assign tmo_expired = (tmo_inc >= TmoLimit);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      step_q      <= SqStart;
      wr_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wdata_q     <= 8'd0;
      count_q     <= 4'd0;
      idx_q       <= 4'd0;
      tmo_q       <= 16'd0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
      RD_DATA     <= 8'd0;
      RD_VALID    <= 1'b0;
      RD_INDEX    <= 4'd0;
      CPU_WE      <= 1'b0;
      CPU_DATA_IN <= 32'd0;
    end else begin
      CPU_WE   <= 1'b0;
      DONE     <= 1'b0;
      RD_VALID <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (GO) begin
            wr_q        <= WR;
            dev_q       <= DEV_ADDR;
            reg_q       <= REG_ADDR;
            wdata_q     <= WDATA;
            count_q     <= COUNT;
            idx_q       <= 4'd0;
            step_q      <= SqStart;
            tmo_q       <= 16'd0;
            ERROR       <= 1'b0;
            BUSY        <= 1'b1;
            CPU_WE      <= 1'b1;
            CPU_DATA_IN <= CmdStart;
            state_q     <= StIssue;
          end
        end
        StIssue: state_q <= StHold;
        // i2c_cpu busy only becomes visible one cycle after WE.
        StHold:  state_q <= StWait;
        StWait: begin
          if (cpu_busy) begin
            tmo_q <= tmo_inc;
            // Bus assumed hung: abort without a STOP.
            if (tmo_expired) begin
              ERROR   <= 1'b1;
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            if (nxt_err) ERROR <= 1'b1;
            if (rd_fire) begin
              RD_DATA  <= CPU_DATA_OUT[7:0];
              RD_INDEX <= idx_q;
              RD_VALID <= 1'b1;
            end
            if (nxt_finish) begin
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
              state_q <= StIdle;
            end else begin
              step_q      <= nxt_step;
              idx_q       <= nxt_idx;
              tmo_q       <= 16'd0;
              CPU_WE      <= 1'b1;
              CPU_DATA_IN <= nxt_word;
              state_q     <= StIssue;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer with a behavioural i2c_cpu model
// and scoreboard queues for issued primitive words and received bytes.
module tb_i2c_reg_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        GO = 1'b0;
  logic        WR = 1'b0;
  logic [6:0]  DEV_ADDR = 7'd0;
  logic [7:0]  REG_ADDR = 8'd0;
  logic [7:0]  WDATA = 8'd0;
  logic [3:0]  COUNT = 4'd0;
  logic [31:0] CPU_DATA_OUT = 32'd0;
  logic        BUSY, DONE, ERROR, RD_VALID, CPU_WE;
  logic [7:0]  RD_DATA;
  logic [3:0]  RD_INDEX;
  logic [31:0] CPU_DATA_IN;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(20)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .GO           (GO),
    .WR           (WR),
    .DEV_ADDR     (DEV_ADDR),
    .REG_ADDR     (REG_ADDR),
    .WDATA        (WDATA),
    .COUNT        (COUNT),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERROR        (ERROR),
    .RD_DATA      (RD_DATA),
    .RD_VALID     (RD_VALID),
    .RD_INDEX     (RD_INDEX),
    .CPU_WE       (CPU_WE),
    .CPU_DATA_IN  (CPU_DATA_IN),
    .CPU_DATA_OUT (CPU_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_words[$];
  logic [11:0] exp_rd[$];
  logic [7:0]  rd_bytes[$];

  int          lat = 3;
  int          busy_left = 0;
  bit          hold_busy = 0;
  bit          nack_next = 0;
  logic [31:0] cur_word = 32'd0;
  int          we_seen = 0, rd_seen = 0, done_seen = 0;
  int          tick_no = 0, we_tick = 0, done_tick = 0;
  logic        err_at_done = 1'b0, busy_at_done = 1'b0;

  // One clock: wait for the falling edge, observe DUT outputs, advance the i2c_cpu model.
  task automatic tick();
    logic [7:0]  b;
    logic        nk;
    logic [11:0] e;
    @(negedge CLK);
    tick_no++;
    if (!RESET_N) return;
    if (RD_VALID) begin
      rd_seen++;
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got index=%0d data=%02h, required no RD_VALID",
                 RD_INDEX, RD_DATA);
      end else begin
        e = exp_rd.pop_front();
        if ({RD_INDEX, RD_DATA} !== e) begin
          errors++;
          $display("FAIL rd_byte: got index=%0d data=%02h, required index=%0d data=%02h",
                   RD_INDEX, RD_DATA, e[11:8], e[7:0]);
        end
      end
    end
    if (DONE) begin
      done_seen++;
      done_tick    = tick_no;
      err_at_done  = ERROR;
      busy_at_done = BUSY;
    end
    if (CPU_WE) begin
      we_seen++;
      we_tick = tick_no;
      checks++;
      if (exp_words.size() == 0) begin
        errors++;
        $display("FAIL cpu_word_unexpected: got %08h, required no CPU_WE", CPU_DATA_IN);
      end else begin
        e = 12'd0;
        cur_word = exp_words.pop_front();
        if (CPU_DATA_IN !== cur_word) begin
          errors++;
          $display("FAIL cpu_word: got %08h, required %08h", CPU_DATA_IN, cur_word);
        end
      end
      cur_word     = CPU_DATA_IN;
      CPU_DATA_OUT = 32'h8000_0000;
      busy_left    = lat;
    end else if (CPU_DATA_OUT[31] && !hold_busy) begin
      busy_left--;
      if (busy_left <= 0) begin
        b  = 8'd0;
        nk = 1'b0;
        if (cur_word[17] && cur_word[7:0] == 8'hFF) begin
          if (rd_bytes.size() > 0) b = rd_bytes.pop_front();
        end else if (cur_word[17]) begin
          nk        = nack_next;
          nack_next = 1'b0;
        end
        CPU_DATA_OUT = {23'd0, nk, b};
      end
    end
  endtask

  task automatic go(input logic wr, input logic [6:0] dev, input logic [7:0] ra,
                    input logic [7:0] wd, input logic [3:0] cnt);
    WR = wr; DEV_ADDR = dev; REG_ADDR = ra; WDATA = wd; COUNT = cnt;
    GO = 1'b1;
    tick();
    GO = 1'b0;
  endtask

  task automatic clear_counts();
    we_seen = 0; rd_seen = 0; done_seen = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_seen == 0; i++) tick();
  endtask

  task automatic push_write(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    exp_words.push_back(32'h0004_0000);
    exp_words.push_back(32'h0002_0100 | {24'd0, dev, 1'b0});
    exp_words.push_back(32'h0002_0100 | {24'd0, ra});
    exp_words.push_back(32'h0002_0100 | {24'd0, wd});
    exp_words.push_back(32'h0001_0000);
  endtask

  task automatic push_read(input logic [6:0] dev, input logic [7:0] ra, input int cnt,
                           input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    logic [3:0] idx;
    exp_words.push_back(32'h0004_0000);
    exp_words.push_back(32'h0002_0100 | {24'd0, dev, 1'b0});
    exp_words.push_back(32'h0002_0100 | {24'd0, ra});
    exp_words.push_back(32'h0001_0000);
    if (cnt != 0) begin
      exp_words.push_back(32'h0004_0000);
      exp_words.push_back(32'h0002_0100 | {24'd0, dev, 1'b1});
      for (int i = 0; i < cnt; i++) begin
        exp_words.push_back((i == cnt - 1) ? 32'h0002_01FF : 32'h0002_00FF);
        b   = base + 8'(i) * step;
        idx = 4'(i);
        rd_bytes.push_back(b);
        exp_rd.push_back({idx, b});
      end
      exp_words.push_back(32'h0001_0000);
    end
  endtask

  task automatic check_txn_end(input string name, input logic exp_err, input int exp_rd_cnt);
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL %s_done: got %0d DONE pulses, required 1", name, done_seen);
    end
    checks++;
    if (err_at_done !== exp_err || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: got ERROR=%b BUSY=%b at DONE, required ERROR=%b BUSY=0",
               name, err_at_done, busy_at_done, exp_err);
    end
    checks++;
    if (exp_words.size() != 0 || rd_seen != exp_rd_cnt || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words left, %0d reads (%0d left), required 0, %0d, 0",
               name, exp_words.size(), rd_seen, exp_rd.size(), exp_rd_cnt);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    checks++;
    if ({BUSY, DONE, ERROR, RD_VALID, CPU_WE} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %05b, required 00000", {BUSY, DONE, ERROR, RD_VALID, CPU_WE});
    end
    checks++;
    if ({RD_DATA, RD_INDEX, CPU_DATA_IN} !== 44'd0) begin
      errors++;
      $display("FAIL reset_data: got %0h/%0h/%0h, required 0/0/0", RD_DATA, RD_INDEX, CPU_DATA_IN);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_write();
    clear_counts();
    push_write(7'h68, 8'h6B, 8'h00);
    go(1'b1, 7'h68, 8'h6B, 8'h00, 4'd0);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL write_busy: got BUSY=%b after GO, required 1", BUSY);
    end
    wait_done(300);
    check_txn_end("write", 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    tick();
    push_write(7'h1E, 8'h20, 8'hA5);
    go(1'b1, 7'h1E, 8'h20, 8'hA5, 4'd0);
    wait_done(300);
    check_txn_end("b2b_write", 1'b0, 0);
  endtask

  task automatic test_burst_read();
    clear_counts();
    push_read(7'h68, 8'h3B, 3, 8'h12, 8'h22);
    go(1'b0, 7'h68, 8'h3B, 8'h00, 4'd3);
    wait_done(500);
    check_txn_end("burst3", 1'b0, 3);
    clear_counts();
    push_read(7'h0D, 8'h00, 15, 8'h05, 8'h07);
    go(1'b0, 7'h0D, 8'h00, 8'h00, 4'd15);
    wait_done(1500);
    check_txn_end("burst15", 1'b0, 15);
  endtask

  task automatic test_addr_nack();
    clear_counts();
    nack_next = 1'b1;
    exp_words.push_back(32'h0004_0000);
    exp_words.push_back(32'h0002_01D0);
    exp_words.push_back(32'h0001_0000);
    go(1'b0, 7'h68, 8'h3B, 8'h00, 4'd3);
    wait_done(300);
    check_txn_end("nack", 1'b1, 0);
    tick();
    checks++;
    if (ERROR !== 1'b1) begin
      errors++;
      $display("FAIL nack_hold: got ERROR=%b after DONE, required 1", ERROR);
    end
    clear_counts();
    push_write(7'h68, 8'h1A, 8'h03);
    go(1'b1, 7'h68, 8'h1A, 8'h03, 4'd0);
    checks++;
    if (ERROR !== 1'b0) begin
      errors++;
      $display("FAIL nack_clear: got ERROR=%b after new GO, required 0", ERROR);
    end
    wait_done(300);
    check_txn_end("after_nack", 1'b0, 0);
  endtask

  task automatic test_timeout();
    clear_counts();
    hold_busy = 1'b1;
    exp_words.push_back(32'h0004_0000);
    go(1'b1, 7'h68, 8'h6B, 8'h00, 4'd0);
    wait_done(100);
    check_txn_end("timeout", 1'b1, 0);
    // WE cycle, Hold cycle, then 20 Wait cycles before the DONE register updates.
    checks++;
    if (done_tick - we_tick != 22) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles WE->DONE, required 22", done_tick - we_tick);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (we_seen != 1) begin
      errors++;
      $display("FAIL timeout_no_stop: got %0d CPU_WE, required 1", we_seen);
    end
    hold_busy = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_count0_busy();
    clear_counts();
    push_read(7'h68, 8'h75, 0, 8'h00, 8'h00);
    go(1'b0, 7'h68, 8'h75, 8'h00, 4'd0);
    for (int i = 0; i < 3; i++) tick();
    go(1'b1, 7'h22, 8'h44, 8'h66, 4'd7);
    wait_done(300);
    check_txn_end("count0", 1'b0, 0);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (we_seen != 4) begin
      errors++;
      $display("FAIL count0_words: got %0d CPU_WE, required 4", we_seen);
    end
  endtask

  task automatic test_async_reset();
    clear_counts();
    push_read(7'h68, 8'h3B, 5, 8'h21, 8'h10);
    go(1'b0, 7'h68, 8'h3B, 8'h00, 4'd5);
    for (int i = 0; i < 300 && we_seen < 9; i++) tick();
    checks++;
    if (we_seen != 9) begin
      errors++;
      $display("FAIL rst_reach: got %0d CPU_WE, required 9", we_seen);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({BUSY, CPU_WE, RD_VALID, DONE, ERROR} !== 5'b0 || CPU_DATA_IN !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: got BUSY/WE/VALID/DONE/ERR=%05b DATA_IN=%08h, required 0/0",
               {BUSY, CPU_WE, RD_VALID, DONE, ERROR}, CPU_DATA_IN);
    end
    exp_words.delete();
    exp_rd.delete();
    rd_bytes.delete();
    CPU_DATA_OUT = 32'd0;
    busy_left    = 0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    clear_counts();
    push_read(7'h68, 8'h3B, 4, 8'h0A, 8'h31);
    go(1'b0, 7'h68, 8'h3B, 8'h00, 4'd4);
    wait_done(600);
    check_txn_end("after_rst", 1'b0, 4);
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_burst_read();
    test_addr_nack();
    test_timeout();
    test_count0_busy();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
